pulse_train_ctrl: RTL and testbench

- Sequencing core behind the pulse generator's AXI4-Lite register slave.
- Consumes the control, period and width/count register words; runs a pulse-train state machine; drives `pulse_o`.
- Returns a status word to the slave's read-only register 1 and raises a completion interrupt.

---
 rtl/pulse_train_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_pulse_train_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_train_ctrl.sv
// Pulse-train sequencer behind the pulse generator register slave: shadowed
// period/width/count, HIGH/LOW phase timing, sticky status and completion irq.
// Optional external-trigger arming is built when PULSE_TRAIN_CTRL_TRIG_EN is defined.
module pulse_train_ctrl #(
  parameter int unsigned PERIOD_WIDTH = 32,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [31:0] ctrl_i,
  input  logic [31:0] period_i,
  input  logic [31:0] shape_i,
`ifdef PULSE_TRAIN_CTRL_TRIG_EN
  input  logic        trig_i,
`endif
  output logic [31:0] status_o,
  output logic        pulse_o,
  output logic        irq_o
);

`ifdef PULSE_TRAIN_CTRL_TRIG_EN
  typedef enum logic [1:0] {IDLE, HIGH, LOW, ARMED} state_t;
`else
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
`endif

  localparam logic [PERIOD_WIDTH-1:0] PH_ONE  = PERIOD_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]    CNT_ONE = CNT_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [PERIOD_WIDTH-1:0] phase_q, phase_d;
  logic [CNT_WIDTH-1:0]    count_q, count_d;
  logic [PERIOD_WIDTH-1:0] per_q, per_d;
  logic [15:0]             width_q, width_d;
  logic [CNT_WIDTH-1:0]    num_q, num_d;
  logic                    done_q, done_d;
  logic                    cfg_err_q, cfg_err_d;
  logic                    aborted_q, aborted_d;
  logic                    start_prev_q, start_prev_d;
  logic                    pulse_q, pulse_d;
  logic                    irq_q, irq_d;

  logic                    start_evt;
  logic                    stop;
  logic                    cfg_ok;
  logic                    armed;
  logic [PERIOD_WIDTH-1:0] per_in;
  logic [15:0]             width_in;
  logic [CNT_WIDTH-1:0]    num_in;
  logic [31:0]             per_ext;
  logic [31:0]             width_ext;
  logic                    unused_bits;

`ifdef PULSE_TRAIN_CTRL_TRIG_EN
  logic trig_meta_q, trig_sync_q, trig_prev_q, trig_evt_q;
  logic trig_evt_d;

  always_comb begin
    trig_evt_d = trig_sync_q & ~trig_prev_q;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      trig_meta_q <= 1'b0;
      trig_sync_q <= 1'b0;
      trig_prev_q <= 1'b0;
      trig_evt_q  <= 1'b0;
    end else begin
      trig_meta_q <= trig_i;
      trig_sync_q <= trig_meta_q;
      trig_prev_q <= trig_sync_q;
      trig_evt_q  <= trig_evt_d;
    end
  end

  assign armed = (state_q == ARMED);
`else
  assign armed = 1'b0;
`endif

  assign start_evt   = ctrl_i[0] & ~start_prev_q;
  assign stop        = ctrl_i[1];
  assign per_in      = period_i[PERIOD_WIDTH-1:0];
  assign width_in    = shape_i[15:0];
  assign num_in      = shape_i[16 +: CNT_WIDTH];
  assign per_ext     = 32'(per_in);
  assign width_ext   = 32'(width_in);
  assign cfg_ok      = (width_in != 16'd0) && (per_ext >= 32'd2) && (width_ext < per_ext);
  assign unused_bits = ^{ctrl_i, period_i, shape_i};

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    count_d      = count_q;
    per_d        = per_q;
    width_d      = width_q;
    num_d        = num_q;
    done_d       = done_q;
    cfg_err_d    = cfg_err_q;
    aborted_d    = aborted_q;
    irq_d        = 1'b0;
    start_prev_d = ctrl_i[0];

    case (state_q)
      IDLE: begin
        if (start_evt && !stop) begin
          if (cfg_ok) begin
            per_d     = per_in;
            width_d   = width_in;
            num_d     = num_in;
            done_d    = 1'b0;
            cfg_err_d = 1'b0;
            aborted_d = 1'b0;
            count_d   = '0;
            phase_d   = PERIOD_WIDTH'(width_in - 16'd1);
`ifdef PULSE_TRAIN_CTRL_TRIG_EN
            state_d   = ctrl_i[4] ? ARMED : HIGH;
`else
            state_d   = HIGH;
`endif
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      HIGH: begin
        if (stop) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (phase_q == '0) begin
          state_d = LOW;
          phase_d = per_q - PERIOD_WIDTH'(width_q) - PH_ONE;
          count_d = count_q + CNT_ONE;
        end else begin
          phase_d = phase_q - PH_ONE;
        end
      end
      LOW: begin
        if (stop) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (phase_q == '0) begin
          // count already includes the pulse that just finished its HIGH phase
          if (num_q != '0 && count_q == num_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
            irq_d   = 1'b1;
          end else begin
            state_d = HIGH;
            phase_d = PERIOD_WIDTH'(width_q - 16'd1);
          end
        end else begin
          phase_d = phase_q - PH_ONE;
        end
      end
`ifdef PULSE_TRAIN_CTRL_TRIG_EN
      ARMED: begin
        if (stop) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (trig_evt_q) begin
          state_d = HIGH;
          phase_d = PERIOD_WIDTH'(width_q - 16'd1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // output follows the next state so the pulse register lines up with the state register
    pulse_d = (state_d == HIGH) ^ ctrl_i[3];
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      count_q      <= '0;
      per_q        <= '0;
      width_q      <= '0;
      num_q        <= '0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      aborted_q    <= 1'b0;
      start_prev_q <= 1'b0;
      pulse_q      <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      count_q      <= count_d;
      per_q        <= per_d;
      width_q      <= width_d;
      num_q        <= num_d;
      done_q       <= done_d;
      cfg_err_q    <= cfg_err_d;
      aborted_q    <= aborted_d;
      start_prev_q <= start_prev_d;
      pulse_q      <= pulse_d;
      irq_q        <= irq_d;
    end
  end

  assign status_o = {16'(count_q), 11'd0, armed, aborted_q, cfg_err_q, done_q,
                     (state_q != IDLE)};
  assign pulse_o  = pulse_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_pulse_train_ctrl.sv
// Self-checking bench for pulse_train_ctrl: randomized pulse-train configurations
// compared against a closed-form timing model (phase = t mod P, count = (t+P-W)/P).
module tb_pulse_train_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ctrl, period, shape;
  logic [31:0] status, status2;
  logic        pulse, pulse2, irq, irq2;
`ifdef PULSE_TRAIN_CTRL_TRIG_EN
  logic        trig;
`endif
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pulse_train_ctrl dut (
    .ACLK(clk), .ARESET(rst), .ctrl_i(ctrl), .period_i(period), .shape_i(shape),
`ifdef PULSE_TRAIN_CTRL_TRIG_EN
    .trig_i(trig),
`endif
    .status_o(status), .pulse_o(pulse), .irq_o(irq)
  );

  pulse_train_ctrl #(.PERIOD_WIDTH(32), .CNT_WIDTH(2)) dut_w2 (
    .ACLK(clk), .ARESET(rst), .ctrl_i(ctrl), .period_i(period), .shape_i(shape),
`ifdef PULSE_TRAIN_CTRL_TRIG_EN
    .trig_i(trig),
`endif
    .status_o(status2), .pulse_o(pulse2), .irq_o(irq2)
  );

  // t = number of rising edges after the start edge (t = 0 is the cycle right after it)
  function automatic bit m_done(int t, int p, int n);
    return (n != 0) && (t >= n * p);
  endfunction

  function automatic bit m_active(int t, int p, int w, int n);
    if (m_done(t, p, n)) return 1'b0;
    return (t % p) < w;
  endfunction

  function automatic int m_count(int t, int p, int w, int n);
    if (m_done(t, p, n)) return n;
    return (t + p - w) / p;
  endfunction

  function automatic logic [31:0] m_status(int t, int p, int w, int n);
    bit d;
    d = m_done(t, p, n);
    return {16'(m_count(t, p, w, n)), 11'd0, 3'b000, d, ~d};
  endfunction

  task automatic do_reset();
    rst    = 1'b1;
    ctrl   = '0;
    period = '0;
    shape  = '0;
`ifdef PULSE_TRAIN_CTRL_TRIG_EN
    trig   = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // drives a start edge; returns at the sample point t = 0
  task automatic start_run(input logic [31:0] bits);
    ctrl = bits | 32'h1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; ctrl = '0; period = '0; shape = '0;
`ifdef PULSE_TRAIN_CTRL_TRIG_EN
    trig = 1'b0;
`endif
    #1;
    checks++; if (status !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=0", status); end
    checks++; if (pulse !== 1'b0) begin failures++; $display("FAIL reset_pulse got=%b exp=0", pulse); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (status !== 32'h0) begin failures++; $display("FAIL idle_status got=%h exp=0", status); end
    checks++; if (pulse !== 1'b0) begin failures++; $display("FAIL idle_pulse got=%b exp=0", pulse); end
  endtask

  task automatic test_basic_run();
    int p = 10, w = 3, n = 4, irqs = 0;
    do_reset();
    period = p; shape = {16'(n), 16'(w)};
    start_run('0);
    for (int t = 0; t <= n * p + 3; t++) begin
      checks++;
      if (pulse !== m_active(t, p, w, n)) begin
        failures++; $display("FAIL basic_pulse t=%0d got=%b exp=%b", t, pulse, m_active(t, p, w, n));
      end
      checks++;
      if (status !== m_status(t, p, w, n)) begin
        failures++; $display("FAIL basic_status t=%0d got=%h exp=%h", t, status, m_status(t, p, w, n));
      end
      if (t == n * p) begin
        checks++; if (status !== 32'h0004_0002) begin failures++; $display("FAIL basic_final got=%h exp=00040002", status); end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL basic_irq got=%b exp=1", irq); end
      end
      if (irq === 1'b1) irqs++;
      @(negedge clk);
    end
    checks++; if (irqs != 1) begin failures++; $display("FAIL basic_irq_count got=%0d exp=1", irqs); end
  endtask

  task automatic test_cfg_err();
    do_reset();
    period = 10; shape = {16'd1, 16'd10};
    start_run('0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (pulse !== 1'b0) begin failures++; $display("FAIL cfgerr_pulse got=%b exp=0", pulse); end
      checks++; if (status !== 32'h4) begin failures++; $display("FAIL cfgerr_status got=%h exp=4", status); end
      @(negedge clk);
    end
    ctrl = '0; shape = {16'd1, 16'd0};
    @(negedge clk);
    start_run('0);
    checks++; if (status !== 32'h4) begin failures++; $display("FAIL cfgerr_w0 got=%h exp=4", status); end
    ctrl = '0; shape = {16'd1, 16'd4};
    @(negedge clk);
    start_run('0);
    for (int t = 0; t <= 11; t++) begin
      checks++;
      if (status !== m_status(t, 10, 4, 1) || pulse !== m_active(t, 10, 4, 1)) begin
        failures++; $display("FAIL cfgerr_rerun t=%0d got=%h/%b exp=%h/%b", t, status, pulse,
                             m_status(t, 10, 4, 1), m_active(t, 10, 4, 1));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random_runs();
    logic [31:0] prev = '0;
    do_reset();
    for (int it = 0; it < 8; it++) begin
      int p, w, n;
      bit pol, bad;
      pol = 1'($urandom_range(0, 1));
      bad = ($urandom_range(0, 3) == 0);
      p = $urandom_range(2, 14);
      w = $urandom_range(1, p - 1);
      n = $urandom_range(1, 4);
      if (bad) w = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(p, p + 3);
      ctrl = {28'd0, pol, 3'b000};
      period = p; shape = {16'(n), 16'(w)};
      @(negedge clk);
      start_run({28'd0, pol, 3'b000});
      if (bad) begin
        prev = prev | 32'h4;
        for (int t = 0; t < 2; t++) begin
          checks++;
          if (status !== prev || pulse !== pol) begin
            failures++; $display("FAIL rand_bad it=%0d got=%h/%b exp=%h/%b", it, status, pulse, prev, pol);
          end
          @(negedge clk);
        end
      end else begin
        for (int t = 0; t <= n * p + 1; t++) begin
          checks++;
          if (pulse !== (m_active(t, p, w, n) ^ pol)) begin
            failures++; $display("FAIL rand_pulse it=%0d p=%0d w=%0d n=%0d t=%0d got=%b", it, p, w, n, t, pulse);
          end
          checks++;
          if (status !== m_status(t, p, w, n) || irq !== (t == n * p)) begin
            failures++; $display("FAIL rand_status it=%0d t=%0d got=%h irq=%b exp=%h", it, t, status, irq,
                                 m_status(t, p, w, n));
          end
          @(negedge clk);
        end
        prev = m_status(n * p, p, w, n);
      end
    end
  endtask

  task automatic test_shadow_polarity();
    int p = 10, w = 3, n = 2;
    bit pol = 1'b0;
    do_reset();
    period = p; shape = {16'(n), 16'(w)};
    start_run('0);
    for (int t = 0; t <= n * p + 2; t++) begin
      checks++;
      if (pulse !== (m_active(t, p, w, n) ^ pol) || status !== m_status(t, p, w, n)) begin
        failures++; $display("FAIL shadow t=%0d got=%b/%h exp=%b/%h", t, pulse, status,
                             m_active(t, p, w, n) ^ pol, m_status(t, p, w, n));
      end
      if (t == 5) begin period = 20; shape = {16'd9, 16'd7}; ctrl = '0; end
      if (t == 7) ctrl = 32'h1;
      if (t == 12) begin
        ctrl = ctrl | 32'h8;
        #1;
        checks++;
        if (pulse !== (m_active(t, p, w, n) ^ pol)) begin
          failures++; $display("FAIL polarity_early got=%b exp=%b", pulse, m_active(t, p, w, n) ^ pol);
        end
        pol = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stop();
    for (int it = 0; it < 4; it++) begin
      int p, w, n, ts;
      logic [31:0] exp_st;
      p = $urandom_range(2, 12);
      w = $urandom_range(1, p - 1);
      n = (it % 2 == 0) ? 0 : 3;
      ts = $urandom_range(0, 3 * p - 1);
      do_reset();
      period = p; shape = {16'(n), 16'(w)};
      start_run('0);
      for (int t = 0; t < ts; t++) @(negedge clk);
      ctrl = 32'h2;
      @(negedge clk);
      exp_st = {16'(m_count(ts, p, w, n)), 16'h0008};
      checks++; if (pulse !== 1'b0) begin failures++; $display("FAIL stop_pulse it=%0d got=%b exp=0", it, pulse); end
      checks++; if (status !== exp_st) begin failures++; $display("FAIL stop_status it=%0d got=%h exp=%h", it, status, exp_st); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL stop_irq it=%0d got=%b exp=0", it, irq); end
      ctrl = 32'h3;
      @(negedge clk);
      checks++;
      if (status !== exp_st || pulse !== 1'b0) begin
        failures++; $display("FAIL stop_start_held it=%0d got=%h exp=%h", it, status, exp_st);
      end
    end
  endtask

  task automatic test_wrap();
    int p = 4, w = 1;
    do_reset();
    period = p; shape = {16'd0, 16'(w)};
    start_run('0);
    for (int t = 0; t <= 25; t++) begin
      logic [31:0] e;
      e = {16'(m_count(t, p, w, 0) % 4), 16'h0001};
      checks++;
      if (status2 !== e || pulse2 !== m_active(t, p, w, 0) || irq2 !== 1'b0) begin
        failures++; $display("FAIL wrap t=%0d got=%h/%b/%b exp=%h/%b/0", t, status2, pulse2, irq2, e,
                             m_active(t, p, w, 0));
      end
      @(negedge clk);
    end
    ctrl = 32'h2;
    @(negedge clk);
    checks++;
    if (status2[15:0] !== 16'h0008 || pulse2 !== 1'b0 || irq2 !== 1'b0) begin
      failures++; $display("FAIL wrap_stop got=%h/%b/%b exp=xxxx0008/0/0", status2, pulse2, irq2);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    period = 10; shape = {16'd0, 16'd5};
    start_run('0);
    @(negedge clk);
    checks++; if (pulse !== 1'b1) begin failures++; $display("FAIL areset_pre got=%b exp=1", pulse); end
    #1 rst = 1'b1;
    #1;
    checks++; if (pulse !== 1'b0) begin failures++; $display("FAIL areset_pulse got=%b exp=0", pulse); end
    checks++; if (status !== 32'h0) begin failures++; $display("FAIL areset_status got=%h exp=0", status); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL areset_irq got=%b exp=0", irq); end
    @(negedge clk);
    rst = 1'b0;
    ctrl = '0;
  endtask

`ifdef PULSE_TRAIN_CTRL_TRIG_EN
  task automatic test_trig();
    int p = 6, w = 2, n = 1;
    do_reset();
    period = p; shape = {16'(n), 16'(w)};
    start_run(32'h10);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (status !== 32'h11 || pulse !== 1'b0) begin
        failures++; $display("FAIL armed i=%0d got=%h/%b exp=00000011/0", i, status, pulse);
      end
      @(negedge clk);
    end
    trig = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++; if (pulse !== 1'b0) begin failures++; $display("FAIL trig_early k=%0d got=%b exp=0", k, pulse); end
    end
    @(negedge clk);
    for (int t = 0; t <= n * p + 1; t++) begin
      checks++;
      if (pulse !== m_active(t, p, w, n) || status !== m_status(t, p, w, n) || irq !== (t == n * p)) begin
        failures++; $display("FAIL trig_run t=%0d got=%b/%h/%b exp=%b/%h", t, pulse, status, irq,
                             m_active(t, p, w, n), m_status(t, p, w, n));
      end
      @(negedge clk);
    end
    trig = 1'b0; ctrl = 32'h10;
    @(negedge clk);
    start_run(32'h10);
    checks++; if (status !== 32'h11) begin failures++; $display("FAIL rearm got=%h exp=00000011", status); end
    ctrl = 32'h12;
    @(negedge clk);
    checks++;
    if (status !== 32'h8 || pulse !== 1'b0 || irq !== 1'b0) begin
      failures++; $display("FAIL armed_stop got=%h/%b/%b exp=00000008/0/0", status, pulse, irq);
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_basic_run();
    test_cfg_err();
    test_random_runs();
    test_shadow_polarity();
    test_stop();
    test_wrap();
    test_async_reset();
`ifdef PULSE_TRAIN_CTRL_TRIG_EN
    test_trig();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
